// File: rtl/hp2vga_pkg.sv
// Shared types and defaults for the PLL bring-up / reset sequencing logic.
package hp2vga_pkg;

  // Sequencer states; encodings outside this set fall back to PLL_RST.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_t;

  // Defaults sized for a 20 MHz reference clock.
  localparam int DEF_PLL_RESET_CYCLES    = 20;    // 1 us RESETB low hold
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 2000;  // 100 us per lock attempt
  localparam int DEF_LOCK_STABLE_CYCLES  = 256;   // consecutive lock cycles
  localparam int DEF_MAX_RETRIES         = 3;     // attempts before FAULT

  localparam int LOSS_COUNT_W = 8;

  // Largest of three cycle parameters, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL out of reset, waits for a stable lock with bounded retries,
// then releases the fast-domain core reset. Lock loss restarts the sequence.
module pll_reset_sequencer
  import hp2vga_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    PLL_LOCK,
  output logic                    PLL_RESETB,
  output logic                    PLL_BYPASS,
  output logic                    CORE_RESET,
  output logic                    READY,
  output logic                    FAULT,
  output logic [LOSS_COUNT_W-1:0] LOSS_COUNT
);

  localparam int CNT_W   = $clog2(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES)) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic                    lock_s;
  pll_state_t              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [RETRY_W-1:0]      retry_reg, retry_next, retry_inc;
  logic [LOSS_COUNT_W-1:0] loss_reg, loss_next;
  logic resetb_reg, resetb_next;
  logic bypass_reg, bypass_next;
  logic core_rst_reg, core_rst_next;
  logic ready_reg, ready_next;
  logic fault_reg, fault_next;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk  (CLK),
    .srst (RESET),
    .d    (PLL_LOCK),
    .q    (lock_s)
  );

  // State, counters and registered outputs; outputs track the state being entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_PLL_RST;
      cnt_reg      <= '0;
      retry_reg    <= '0;
      loss_reg     <= '0;
      resetb_reg   <= 1'b0;
      bypass_reg   <= 1'b0;
      core_rst_reg <= 1'b1;
      ready_reg    <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      retry_reg    <= retry_next;
      loss_reg     <= loss_next;
      resetb_reg   <= resetb_next;
      bypass_reg   <= bypass_next;
      core_rst_reg <= core_rst_next;
      ready_reg    <= ready_next;
      fault_reg    <= fault_next;
    end
  end

  // Next-state, counter, retry and loss-count logic; lock beats a same-cycle timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    retry_next = retry_reg;
    loss_next  = loss_reg;
    retry_inc  = retry_reg + RETRY_W'(1);
    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_next = retry_inc;
          cnt_next   = '0;
          state_next = (retry_inc < RETRY_MAX) ? ST_PLL_RST : ST_FAULT;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          // A glitch restarts the stability window but is not a failed attempt.
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          retry_next = '0;
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = ST_PLL_RST;
          retry_next = '0;
          if (loss_reg != '1) begin
            loss_next = loss_reg + LOSS_COUNT_W'(1);
          end
        end
      end
      ST_FAULT: begin
        cnt_next = '0;
      end
      default: begin
        state_next = ST_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the state about to be entered, so outputs change with the state.
  always_comb begin
    resetb_next   = 1'b1;
    bypass_next   = 1'b0;
    core_rst_next = 1'b1;
    ready_next    = 1'b0;
    fault_next    = 1'b0;
    case (state_next)
      ST_PLL_RST: resetb_next = 1'b0;
      ST_RUN: begin
        core_rst_next = 1'b0;
        ready_next    = 1'b1;
      end
      ST_FAULT: begin
        resetb_next = 1'b0;
        bypass_next = 1'b1;
        fault_next  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PLL_RESETB = resetb_reg;
  assign PLL_BYPASS = bypass_reg;
  assign CORE_RESET = core_rst_reg;
  assign READY      = ready_reg;
  assign FAULT      = fault_reg;
  assign LOSS_COUNT = loss_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: one instance with default timing,
// one with short timing for the many-loss-event saturation run.
module tb_pll_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PLL_LOCK;
  logic       PLL_RESETB, PLL_BYPASS, CORE_RESET, READY, FAULT;
  logic [7:0] LOSS_COUNT;

  logic       lock_f;
  logic       resetb_f, bypass_f, core_rst_f, ready_f, fault_f;
  logic [7:0] loss_f;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  pll_reset_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PLL_LOCK   (PLL_LOCK),
    .PLL_RESETB (PLL_RESETB),
    .PLL_BYPASS (PLL_BYPASS),
    .CORE_RESET (CORE_RESET),
    .READY      (READY),
    .FAULT      (FAULT),
    .LOSS_COUNT (LOSS_COUNT)
  );

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (40),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (3)
  ) dut_f (
    .CLK        (CLK),
    .RESET      (RESET),
    .PLL_LOCK   (lock_f),
    .PLL_RESETB (resetb_f),
    .PLL_BYPASS (bypass_f),
    .CORE_RESET (core_rst_f),
    .READY      (ready_f),
    .FAULT      (fault_f),
    .LOSS_COUNT (loss_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: got=%0d (t=%0t)", tag, got, $time);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic release_reset();
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resetb"}, PLL_RESETB, 0);
    chk({tag, "_bypass"}, PLL_BYPASS, 0);
    chk({tag, "_core_reset"}, CORE_RESET, 1);
    chk({tag, "_ready"}, READY, 0);
    chk({tag, "_fault"}, FAULT, 0);
    chk({tag, "_loss"}, LOSS_COUNT, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    RESET    = 1'b1;
    PLL_LOCK = 1'b0;
    lock_f   = 1'b0;
    tick(); tick(); tick();
    chk_reset_outputs("por");
    chk("por_fast_loss", loss_f, 0);

    // Nominal: RESETB rises after 20 cycles, lock 500 cycles later, READY at 520+2+1+256.
    release_reset();
    run_to(19);   chk("nom_resetb_low_c19", PLL_RESETB, 0);
    run_to(20);   chk("nom_resetb_high_c20", PLL_RESETB, 1);
    run_to(520);  PLL_LOCK = 1'b1;
    run_to(778);  chk("nom_ready_c778", READY, 0);
                  chk("nom_core_reset_c778", CORE_RESET, 1);
    run_to(779);  chk("nom_ready_c779", READY, 1);
                  chk("nom_core_reset_c779", CORE_RESET, 0);
                  chk("nom_fault", FAULT, 0);
                  chk("nom_bypass", PLL_BYPASS, 0);

    // Lock loss in RUN: CORE_RESET on the third edge after the raw drop.
    run_to(800);  PLL_LOCK = 1'b0;
    run_to(802);  chk("loss_core_reset_c802", CORE_RESET, 0);
    run_to(803);  chk("loss_core_reset_c803", CORE_RESET, 1);
                  chk("loss_count_1", LOSS_COUNT, 1);
                  chk("loss_ready", READY, 0);
                  chk("loss_resetb", PLL_RESETB, 0);
                  PLL_LOCK = 1'b1;
    run_to(1079); chk("relock_ready_c1079", READY, 0);
    run_to(1080); chk("relock_ready_c1080", READY, 1);
                  chk("relock_loss", LOSS_COUNT, 1);

    // RESET pulsed while in RUN.
    run_to(1090); RESET = 1'b1;
    tick();       chk_reset_outputs("rst_in_run");
    PLL_LOCK = 1'b0;
    tick();

    // Glitch: 100 cycles of lock, one low cycle, then high again.
    release_reset();
    run_to(20);   PLL_LOCK = 1'b1;
    run_to(120);  PLL_LOCK = 1'b0;
    run_to(121);  PLL_LOCK = 1'b1;
    run_to(279);  chk("glitch_ready_c279", READY, 0);
    run_to(379);  chk("glitch_ready_c379", READY, 0);
    run_to(380);  chk("glitch_ready_c380", READY, 1);

    // Timeout: no lock, three 20-cycle RESETB pulses 2020 apart, then FAULT.
    RESET = 1'b1; PLL_LOCK = 1'b0;
    tick(); tick();
    release_reset();
    run_to(2019); chk("to_resetb_c2019", PLL_RESETB, 1);
    run_to(2020); chk("to_resetb_c2020", PLL_RESETB, 0);
    run_to(2039); chk("to_resetb_c2039", PLL_RESETB, 0);
    run_to(2040); chk("to_resetb_c2040", PLL_RESETB, 1);
    run_to(4039); chk("to_resetb_c4039", PLL_RESETB, 1);
    run_to(4040); chk("to_resetb_c4040", PLL_RESETB, 0);
    run_to(4060); chk("to_resetb_c4060", PLL_RESETB, 1);
    run_to(6059); chk("to_fault_c6059", FAULT, 0);
    run_to(6060); chk("to_fault_c6060", FAULT, 1);
                  chk("to_bypass_c6060", PLL_BYPASS, 1);
                  chk("to_resetb_c6060", PLL_RESETB, 0);
                  chk("to_core_reset_c6060", CORE_RESET, 1);
                  chk("to_ready_c6060", READY, 0);
                  PLL_LOCK = 1'b1;
    run_to(6500); chk("to_fault_sticky", FAULT, 1);
                  chk("to_bypass_sticky", PLL_BYPASS, 1);
    RESET = 1'b1;
    tick();       chk_reset_outputs("rst_in_fault");
    PLL_LOCK = 1'b0;
    tick();

    // Lock arriving on the very timeout cycle wins: no RESETB pulse, RUN 256 later.
    release_reset();
    run_to(2017); PLL_LOCK = 1'b1;
    run_to(2020); chk("tie_resetb_c2020", PLL_RESETB, 1);
    run_to(2275); chk("tie_ready_c2275", READY, 0);
    run_to(2276); chk("tie_ready_c2276", READY, 1);

    // Saturation on the short-timing instance: 300 loss events.
    RESET = 1'b1; lock_f = 1'b0;
    tick(); tick();
    release_reset();
    for (int i = 1; i <= 300; i++) begin
      lock_f = 1'b1;
      k = 0;
      while (!ready_f && k < 200) begin tick(); k++; end
      if (!ready_f) begin
        chk("sat_ready_timeout", ready_f, 1);
        break;
      end
      lock_f = 1'b0;
      k = 0;
      while (!core_rst_f && k < 6) begin tick(); k++; end
      if (i == 1 || k != 3) chk("sat_core_reset_latency", k, 3);
      if (i == 1 || i == 254 || i == 255 || i == 300)
        chk($sformatf("sat_loss_%0d", i), loss_f, (i > 255) ? 255 : i);
    end
    chk("sat_fault", fault_f, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RESET_CYCLES, default 20, meaning the PLL RESETB low-hold time in CLK cycles (1 us at 20 MHz).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 2000, meaning the maximum wait for LOCK per attempt.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYCLES, default 256, meaning the number of consecutive synchronized-LOCK-high cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, meaning the number of failed lock attempts allowed before FAULT.
REQ-005 The block SHALL have port CLK, input, 1, the 20 MHz reference clock (same net as the PLL REFERENCECLK).
REQ-006 The block SHALL have port RESET, input, 1, the reset: synchronous, active-high.
REQ-007 The block SHALL have port PLL_LOCK, input, 1, the raw PLL LOCK (asynchronous to CLK).
REQ-008 The block SHALL have port PLL_RESETB, output, 1, the active-low PLL reset.
REQ-009 The block SHALL have port PLL_BYPASS, output, 1, the PLL bypass control.
REQ-010 The block SHALL have port CORE_RESET, output, 1, the active-high reset for the 100 MHz domain, held for at least 4 CLK cycles.
REQ-011 The block SHALL have port READY, output, 1, high only in state RUN.
REQ-012 The block SHALL have port FAULT, output, 1, high only in state FAULT.
REQ-013 The block SHALL have port LOSS_COUNT, output, 8, the saturating count of lock-loss events seen while in RUN.

Function
REQ-014 PLL_LOCK SHALL pass through a 2-flop synchronizer; every decision SHALL use the synchronized value (lock_s), giving 2 cycles of latency.
REQ-015 The FSM SHALL have exactly five states: PLL_RST, WAIT_LOCK, STABLE, RUN and FAULT.
REQ-016 In PLL_RST: PLL_RESETB=0 and CORE_RESET=1 for PLL_RESET_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK with the counter cleared.
REQ-017 In WAIT_LOCK: PLL_RESETB=1 and CORE_RESET=1; lock_s=1 -> STABLE (counter cleared); counter reaching LOCK_TIMEOUT_CYCLES-1 without lock -> retry logic.
REQ-018 Retry logic: the retry counter SHALL increment; if it is below MAX_RETRIES -> PLL_RST, otherwise -> FAULT.
REQ-019 In STABLE: CORE_RESET=1; lock_s=0 SHALL send the FSM back to WAIT_LOCK with the counter cleared and no retry increment; LOCK_STABLE_CYCLES consecutive high cycles -> RUN.
REQ-020 In RUN: CORE_RESET=0 and READY=1; lock_s falling SHALL assert CORE_RESET on the next cycle, increment LOSS_COUNT (saturating at 255), clear the retry counter and go to PLL_RST.
REQ-021 In FAULT: PLL_BYPASS=1, PLL_RESETB=0, CORE_RESET=1 and FAULT=1; FAULT SHALL be terminal until RESET.
REQ-022 PLL_BYPASS SHALL be 0 in every state except FAULT.
REQ-023 Entry into RUN SHALL clear the retry counter.
REQ-024 If lock_s rises on the same cycle the WAIT_LOCK timeout expires, lock SHALL win and the FSM SHALL go to STABLE.
REQ-025 All outputs SHALL be registered, with no combinational path from PLL_LOCK to any output.
REQ-026 The counter width SHALL be $clog2 of the largest cycle parameter, +1.

Reset
REQ-027 RESET=1 SHALL, on the next CLK edge, force state=PLL_RST and set PLL_RESETB=0, PLL_BYPASS=0, CORE_RESET=1, READY=0, FAULT=0 and LOSS_COUNT=0, with counters, retries and the synchronizer cleared.
REQ-028 RESET asserted mid-operation, including in RUN or FAULT, SHALL behave identically to power-up reset.
REQ-029 Release of RESET SHALL restart the full sequence from PLL_RST cycle 0.

Structure
REQ-030 The state enum, default parameter values and LOSS_COUNT width SHALL reside in the shared package hp2vga_pkg.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other asynchronous inputs.

Verification
REQ-032 Nominal: RESET released, PLL_LOCK rises 500 cycles later and stays high -> PLL_RESETB rises at cycle 20, READY=1 at cycle 20+500+2+256 (±1), FAULT=0.
REQ-033 Glitch: PLL_LOCK high 100 cycles, low 1 cycle, then high -> the STABLE count restarts and READY is delayed by the glitch offset, with no retry increment.
REQ-034 Timeout: PLL_LOCK held 0 -> three PLL_RST pulses of 20 cycles spaced 2020 cycles apart, then FAULT=1 and PLL_BYPASS=1 permanently.
REQ-035 Loss in RUN: PLL_LOCK drops after READY -> CORE_RESET=1 within 3 cycles, LOSS_COUNT=1, and the sequence completes again after lock returns.
REQ-036 Saturation and reset: 300 loss events -> LOSS_COUNT=255; RESET pulsed in RUN -> all outputs at reset values on the next edge.
